// File: rtl/sign_extend.sv
// sign_extend
//   Widens a narrow immediate/offset field to datapath width by zero- or
//   sign-extension, with an optional left shift by 2 for word-aligned offsets.
//   The result is offered combinationally for same-cycle decode use and as a
//   registered, valid-qualified copy for the next pipeline stage.
//   OUT_W must be at least IN_W + 2 so the shifted form keeps every input bit.
//
// Ports
//   clk       in   1      pipeline clock, rising edge
//   rst       in   1      synchronous active-high reset
//   in_buf    in   IN_W   immediate to extend
//   sext_en   in   1      1 = sign-extend, 0 = zero-extend
//   shl_en    in   1      1 = shift the extended value left by 2
//   in_valid  in   1      qualifies in_buf for the registered path
//   out_shft  out  OUT_W  combinational extended (and optionally shifted) value
//   out_q     out  OUT_W  registered copy of out_shft
//   out_valid out  1      registered in_valid
module sign_extend #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_buf,
  input  logic             sext_en,
  input  logic             shl_en,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_shft,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid
);

  // Fill bit is the input MSB only in sign mode; zero mode fills with 0 even
  // when the MSB is set. An X on the MSB propagates in sign mode.
  function automatic logic signed [OUT_W-1:0] extend_imm(
    input logic [IN_W-1:0] v,
    input logic            sx
  );
    logic fill;
    fill = sx & v[IN_W-1];
    return {{(OUT_W-IN_W){fill}}, v};
  endfunction

  // Bits pushed past OUT_W-1 are discarded.
  function automatic logic signed [OUT_W-1:0] shift_imm(
    input logic signed [OUT_W-1:0] e,
    input logic                    sh
  );
    return sh ? {e[OUT_W-3:0], 2'b00} : e;
  endfunction

  logic signed [OUT_W-1:0] w_ext_p0;
  logic signed [OUT_W-1:0] w_shft_p0;
  logic        [OUT_W-1:0] r_q_p1;
  logic                    r_vld_p1;

  // ---- stage p0: combinational extend/shift ----
  always_comb begin
    w_ext_p0  = extend_imm(in_buf, sext_en);
    w_shft_p0 = shift_imm(w_ext_p0, shl_en);
  end

  assign out_shft = w_shft_p0;

  // ---- stage p1: registered copy ----
  // out_q captures every cycle; consumers qualify it with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_p1   <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_q_p1   <= w_shft_p0;
      r_vld_p1 <= in_valid;
    end
  end

  assign out_q     = r_q_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_sign_extend.sv
module tb_sign_extend;

  logic       clk;
  logic       rst;
  logic [3:0] in_buf;
  logic       sext_en;
  logic       shl_en;
  logic       in_valid;
  logic [5:0] out_shft;
  logic [5:0] out_q;
  logic       out_valid;

  int n_cmp;
  int n_bad;
  logic [5:0] exp_q[$];
  logic rst_prev;
  bit   done;

  sign_extend #(.IN_W(4), .OUT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_buf   (in_buf),
    .sext_en  (sext_en),
    .shl_en   (shl_en),
    .in_valid (in_valid),
    .out_shft (out_shft),
    .out_q    (out_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rst_prev = 1'b0;
  always @(posedge clk) rst_prev <= rst;

  // Monitor: checks reset state after reset edges, otherwise pops the
  // scoreboard whenever the DUT presents a valid result.
  always @(negedge clk) begin
    if (!done) begin
      if (rst_prev) begin
        n_cmp++;
        if (out_q !== 6'b000000 || out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_state: out_q=%b out_valid=%b, required out_q=000000 out_valid=0",
                   out_q, out_valid);
        end
      end else if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stray_valid: out_valid=1 out_q=%b, required out_valid=0", out_q);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          if (out_q !== e) begin
            n_bad++;
            $display("FAIL out_q: got %b, required %b", out_q, e);
          end
        end
      end
    end
  end

  // Apply one vector a little after a rising edge, check the combinational
  // result, queue the registered expectation, then advance one clock.
  task automatic drive(input logic [3:0] b, input logic sx, input logic sh,
                       input logic v, input logic [5:0] exp_shft, input logic r);
    in_buf   = b;
    sext_en  = sx;
    shl_en   = sh;
    in_valid = v;
    rst      = r;
    #1;
    n_cmp++;
    if (out_shft !== exp_shft) begin
      n_bad++;
      $display("FAIL out_shft in=%b sx=%b sh=%b: got %b, required %b",
               b, sx, sh, out_shft, exp_shft);
    end
    if (v && !r) exp_q.push_back(exp_shft);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; done = 1'b0;
    rst = 1'b1; in_buf = '0; sext_en = 1'b0; shl_en = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    // reset for two cycles
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b1);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b1);
    // zero-extend
    drive(4'b0010, 1'b0, 1'b0, 1'b1, 6'b000010, 1'b0);
    drive(4'b0100, 1'b0, 1'b0, 1'b1, 6'b000100, 1'b0);
    drive(4'b1110, 1'b0, 1'b0, 1'b1, 6'b001110, 1'b0);
    // sign-extend
    drive(4'b1110, 1'b1, 1'b0, 1'b1, 6'b111110, 1'b0);
    drive(4'b0111, 1'b1, 1'b0, 1'b1, 6'b000111, 1'b0);
    drive(4'b1000, 1'b1, 1'b0, 1'b1, 6'b111000, 1'b0);
    // shift by 2
    drive(4'b1110, 1'b0, 1'b1, 1'b1, 6'b111000, 1'b0);
    drive(4'b1110, 1'b1, 1'b1, 1'b1, 6'b111000, 1'b0);
    drive(4'b0011, 1'b0, 1'b1, 1'b1, 6'b001100, 1'b0);
    drive(4'b1011, 1'b1, 1'b1, 1'b1, 6'b101100, 1'b0);
    drive(4'b0011, 1'b1, 1'b1, 1'b0, 6'b001100, 1'b0);
    // single pulse then idle
    drive(4'b0101, 1'b0, 1'b0, 1'b1, 6'b000101, 1'b0);
    drive(4'b0101, 1'b0, 1'b0, 1'b0, 6'b000101, 1'b0);
    drive(4'b0110, 1'b0, 1'b0, 1'b0, 6'b000110, 1'b0);
    // reset wins over in_valid; out_shft keeps tracking during reset
    drive(4'b1010, 1'b1, 1'b0, 1'b1, 6'b111010, 1'b1);
    drive(4'b1100, 1'b0, 1'b1, 1'b1, 6'b110000, 1'b1);
    // capture resumes
    drive(4'b1001, 1'b0, 1'b0, 1'b1, 6'b001001, 1'b0);
    drive(4'b1111, 1'b1, 1'b0, 1'b1, 6'b111111, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0);
    @(negedge clk);
    #1;
    done = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results never presented, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sign_extend.md
# sign_extend

Width-extension unit for the pipelined datapath's immediate/offset field. Takes a narrow immediate (default 4 bits) and produces a wider operand (default 6 bits) by zero- or sign-extension, with an optional left-shift-by-2 for word-aligned offsets. The extended value is available combinationally for same-cycle use in decode, and as a registered, valid-qualified copy for the next pipeline stage.

## Interface
Parameters:
- IN_W, 4, input immediate width
- OUT_W, 6, output width; must satisfy OUT_W >= IN_W + 2

Ports:
- clk  input  1  pipeline clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- in_buf  input  IN_W  immediate to extend
- sext_en  input  1  1 = sign-extend, 0 = zero-extend (0 is the default mode)
- shl_en  input  1  1 = shift the extended value left by 2
- in_valid  input  1  qualifies in_buf for the registered path
- out_shft  output  OUT_W  combinational extended result
- out_q  output  OUT_W  registered copy of out_shft
- out_valid  output  1  registered in_valid

Clock is `clk`. Reset is `rst`: one clock; reset is synchronous and active-high.

## Operation
- Extension rule, with E = the OUT_W-bit value:
  - sext_en=0: E = {(OUT_W-IN_W) zeros, in_buf}
  - sext_en=1: E = {(OUT_W-IN_W) copies of in_buf[IN_W-1], in_buf}
- out_shft = shl_en ? (E << 2), truncated to OUT_W : E.
  - Bits shifted past OUT_W-1 are discarded.
  - With the default widths, shl_en=1 yields {in_buf, 2'b00} regardless of sext_en.
- out_shft is purely combinational in in_buf, sext_en and shl_en. It is unaffected by clk and rst.
- Registered path:
  - On each rising clk with rst=0: out_q <= out_shft and out_valid <= in_valid.
  - out_q updates every cycle whether or not in_valid is high. Consumers qualify it with out_valid.
- No internal state beyond out_q and out_valid. No FSM.
- X/Z on in_buf propagates; no masking.

## Timing
- out_shft: zero latency, settles within the same cycle as the input change.
- out_q / out_valid: 1-cycle latency from inputs sampled at the rising edge.
- Reset values, applied on a rising clk with rst=1: out_q = 0, out_valid = 0.
- Reset wins over in_valid in the same cycle.
- Reset mid-stream: the in-flight value is dropped; out_valid is low in the cycle after reset. Normal capture resumes on the first edge with rst=0.
- Back-to-back in_valid is fully pipelined: one result per cycle, no stalls, no backpressure.

## Test plan
- Zero-extend, positive values: sext_en=0, shl_en=0. Apply in_buf=0010, then 0100 -> out_shft=000010, then 000100, same cycle.
- Zero-extend, MSB set: sext_en=0, in_buf=1110 -> out_shft=001110.
- Sign-extend: sext_en=1. in_buf=1110 -> 111110; in_buf=0111 -> 000111; in_buf=1000 -> 111000.
- Shift: shl_en=1, in_buf=1110 -> 111000 for both sext_en=0 and sext_en=1. in_buf=0011 -> 001100.
- Registered path: apply rst for 2 cycles -> out_q=000000, out_valid=0. Pulse in_valid with in_buf=0101, sext_en=0 -> next cycle out_q=000101, out_valid=1. The following cycle out_valid=0.
- Reset priority: in_valid=1 and rst=1 on the same edge -> out_q=0, out_valid=0. out_shft still tracks in_buf during reset.
